seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_lookup.sv | 24 ++
 rtl/seg7_capture.sv | 160 ++++++++++++++++
 tb/tb_seg7_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared table, constants and state type for the seven-segment capture path
package seg7_pkg;

   localparam int STABLE_CYCLES_DEFAULT = 4;

   // Active-low segment pattern of a dark digit.
   localparam logic [6:0] BLANK = 7'h7F;

   // Lit segments (gfedcba) for hex values 0..F; seg_n is the bitwise inverse.
   localparam logic [6:0] SEG_LIT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } state_e;

   function automatic logic an_single(input logic [3:0] an_n);
      return an_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
   endfunction

   function automatic logic [1:0] an_index(input logic [3:0] an_n);
      case (an_n)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg7_lookup.sv
// rtl/seg7_lookup.sv - maps an active-low segment pattern to a hex nibble plus hit/blank flags
module seg7_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       hit,
   output logic       blank
);

   always_comb begin
      nibble = 4'd0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (~seg_n == SEG_LIT[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      end
   end

   assign blank = (seg_n == BLANK);

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - debounces a scanned seven-segment display and captures each digit as hex
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        upd,
   output logic [1:0]  upd_idx,
   output logic        err,
   output logic [1:0]  err_idx
);

   localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [6:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;
   logic [10:0] cand_q, cand_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  valid_q, valid_d;
   logic        upd_q, upd_d;
   logic [1:0]  upd_idx_q, upd_idx_d;
   logic        err_q, err_d;
   logic [1:0]  err_idx_q, err_idx_d;

   logic        sample_ok;
   logic        same;
   logic        accept;
   logic [1:0]  idx;
   logic [3:0]  nibble;
   logic        hit;
   logic        blank;

   seg7_lookup u_lookup (
      .seg_n  (seg_q),
      .nibble (nibble),
      .hit    (hit),
      .blank  (blank)
   );

   assign sample_ok = an_single(an_q);
   assign idx       = an_index(an_q);
   assign same      = ({an_q, seg_q} == cand_q);

   always_comb begin
      seg_d     = seg_n;
      an_d      = an_n;
      state_d   = state_q;
      cnt_d     = cnt_q;
      cand_d    = cand_q;
      digits_d  = digits_q;
      valid_d   = valid_q;
      upd_d     = 1'b0;
      upd_idx_d = upd_idx_q;
      err_d     = err_q;
      err_idx_d = err_idx_q;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (sample_ok) begin
               state_d = SETTLE;
               cnt_d   = 4'd1;
               cand_d  = {an_q, seg_q};
            end
         end
         SETTLE: begin
            if (!sample_ok) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (!same) begin
               cnt_d  = 4'd1;
               cand_d = {an_q, seg_q};
            end else begin
               if (cnt_q != STABLE_N) cnt_d = cnt_q + 4'd1;
               if (cnt_q == STABLE_N - 4'd1) begin
                  accept  = 1'b1;
                  state_d = HELD;
               end
            end
         end
         HELD: begin
            if (!sample_ok) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (!same) begin
               state_d = SETTLE;
               cnt_d   = 4'd1;
               cand_d  = {an_q, seg_q};
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      if (err_clr) err_d = 1'b0;

      // An illegal capture in the same cycle as err_clr re-arms err with the new index.
      if (accept) begin
         upd_d     = 1'b1;
         upd_idx_d = idx;
         if (hit) begin
            digits_d[{idx, 2'b00} +: 4] = nibble;
            valid_d[idx]                = 1'b1;
         end else begin
            valid_d[idx] = 1'b0;
            if (!blank) begin
               if (!err_q || err_clr) err_idx_d = idx;
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         seg_q     <= 7'h7F;
         an_q      <= 4'hF;
         cand_q    <= 11'h7FF;
         digits_q  <= 16'h0000;
         valid_q   <= 4'h0;
         upd_q     <= 1'b0;
         upd_idx_q <= 2'd0;
         err_q     <= 1'b0;
         err_idx_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         cand_q    <= cand_d;
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         upd_q     <= upd_d;
         upd_idx_q <= upd_idx_d;
         err_q     <= err_d;
         err_idx_q <= err_idx_d;
      end
   end

   assign digits      = digits_q;
   assign digit_valid = valid_q;
   assign upd         = upd_q;
   assign upd_idx     = upd_idx_q;
   assign err         = err_q;
   assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed scoreboard bench for seg7_capture with STABLE_CYCLES=4
module tb_seg7_capture;

   localparam int STABLE = 4;

   logic        clk;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        err_clr;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        upd;
   logic [1:0]  upd_idx;
   logic        err;
   logic [1:0]  err_idx;

   typedef struct {
      int          edge_no;
      logic [1:0]  idx;
      logic [15:0] digits;
      logic [3:0]  valid;
      logic        err;
      logic [1:0]  err_idx;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_n       (seg_n),
      .an_n        (an_n),
      .err_clr     (err_clr),
      .digits      (digits),
      .digit_valid (digit_valid),
      .upd         (upd),
      .upd_idx     (upd_idx),
      .err         (err),
      .err_idx     (err_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Inputs first seen at edge cyc+1 produce upd STABLE edges later.
   task automatic push(input logic [1:0] i, input logic [15:0] d, input logic [3:0] v,
                       input logic e, input logic [1:0] ei);
      exp_t x;
      x.edge_no = cyc + 1 + STABLE;
      x.idx     = i;
      x.digits  = d;
      x.valid   = v;
      x.err     = e;
      x.err_idx = ei;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      if (sb.size() != 0 && sb[0].edge_no == cyc) begin
         exp_t x;
         x = sb.pop_front();
         chk("upd", 32'(upd), 32'd1);
         chk("upd_idx", 32'(upd_idx), 32'(x.idx));
         chk("digits", 32'(digits), 32'(x.digits));
         chk("digit_valid", 32'(digit_valid), 32'(x.valid));
         chk("err", 32'(err), 32'(x.err));
         chk("err_idx", 32'(err_idx), 32'(x.err_idx));
      end else begin
         chk("no_upd", 32'(upd), 32'd0);
      end
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n  = a;
      seg_n = s;
      repeat (n) step();
   endtask

   initial begin
      rst     = 1'b1;
      an_n    = 4'hF;
      seg_n   = 7'h7F;
      err_clr = 1'b0;
      step();
      step();
      chk("rst_digits", 32'(digits), 32'h0);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_upd_idx", 32'(upd_idx), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_err_idx", 32'(err_idx), 32'h0);
      rst = 1'b0;

      // Single digit 0 on position 0, held past acceptance.
      push(2'd0, 16'h0000, 4'b0001, 1'b0, 2'd0);
      hold(4'b1110, 7'h40, 6);
      chk("s1_digits", 32'(digits), 32'h0000);
      chk("s1_valid", 32'(digit_valid), 32'h1);
      chk("s1_err", 32'(err), 32'h0);

      // Anodes off, then a full scan writing 3210.
      hold(4'b1111, 7'h7F, 2);
      push(2'd0, 16'h0000, 4'b0001, 1'b0, 2'd0);
      hold(4'b1110, 7'h40, 5);
      push(2'd1, 16'h0010, 4'b0011, 1'b0, 2'd0);
      hold(4'b1101, 7'h79, 5);
      push(2'd2, 16'h0210, 4'b0111, 1'b0, 2'd0);
      hold(4'b1011, 7'h24, 5);
      push(2'd3, 16'h3210, 4'b1111, 1'b0, 2'd0);
      hold(4'b0111, 7'h30, 5);
      chk("scan_digits", 32'(digits), 32'h3210);
      chk("scan_valid", 32'(digit_valid), 32'hF);

      // Pattern changes one cycle short of acceptance; run restarts on the new one.
      hold(4'b1110, 7'h40, 3);
      push(2'd0, 16'h3211, 4'b1111, 1'b0, 2'd0);
      hold(4'b1110, 7'h79, 6);
      chk("restart_digits", 32'(digits), 32'h3211);

      // Two anodes low never qualifies.
      hold(4'b1100, 7'h40, 10);

      // Illegal pattern sets err; a second one keeps the first index.
      push(2'd2, 16'h3211, 4'b1011, 1'b1, 2'd2);
      hold(4'b1011, 7'h7E, 6);
      chk("err_set", 32'(err), 32'h1);
      chk("err_idx_set", 32'(err_idx), 32'h2);
      chk("err_valid2", 32'(digit_valid[2]), 32'h0);
      push(2'd0, 16'h3211, 4'b1010, 1'b1, 2'd2);
      hold(4'b1110, 7'h7E, 6);

      // err_clr on the same edge as an illegal accept: set wins, index reloads.
      push(2'd1, 16'h3211, 4'b1000, 1'b1, 2'd1);
      an_n  = 4'b1101;
      seg_n = 7'h7E;
      repeat (STABLE) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      repeat (2) step();
      chk("clr_collide_err", 32'(err), 32'h1);

      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_cleared", 32'(err), 32'h0);

      // Blank accept clears valid, pulses upd, no error.
      push(2'd2, 16'h3211, 4'b1000, 1'b0, 2'd1);
      hold(4'b1011, 7'h7F, 6);
      chk("blank_err", 32'(err), 32'h0);

      // Reset at run count 3 discards the run; the restart needs a full run.
      an_n  = 4'b1110;
      seg_n = 7'h40;
      repeat (STABLE) step();
      rst = 1'b1;
      step();
      chk("midrst_upd", 32'(upd), 32'h0);
      chk("midrst_digits", 32'(digits), 32'h0);
      chk("midrst_valid", 32'(digit_valid), 32'h0);
      chk("midrst_err", 32'(err), 32'h0);
      rst = 1'b0;
      push(2'd0, 16'h0000, 4'b0001, 1'b0, 2'd0);
      repeat (24) step();
      chk("final_valid", 32'(digit_valid), 32'h1);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
